dff_capture_bank: RTL and testbench
===================================

Name: dff_capture_bank

Overview:
Parametrised, single-clock successor to the per-bit strobe-clocked capture register. A serial data input is captured into WIDTH storage bits. Each bit is written on a rising edge of its own asynchronous strobe line, which is synchronised and edge-detected inside the block. The block adds a shift mode, per-bit capture tracking, overrun detection and comparison against a target pattern for the puzzle/lock logic downstream.

Parameters:
WIDTH, 8, number of storage bits and strobe channels (>=2)
SYNC_STAGES, 2, synchroniser depth for data_in and each strobe (>=2)
REVERSE, 1, 1: strobe[i] writes data[WIDTH-1-i]; 0: strobe[i] writes data[i]

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
data_in  input  1  asynchronous serial data bit
strobe  input  WIDTH  asynchronous per-channel capture strobes, rising-edge active
mode  input  1  0 = indexed capture, 1 = shift capture
clear  input  1  synchronous clear of stored state
target  input  WIDTH  pattern compared against data
data  output  WIDTH  stored bits
captured  output  WIDTH  per-bit "written since reset/clear" flags
all_captured  output  1  &captured
match  output  1  all_captured && (data == target)
capture_pulse  output  1  one-cycle pulse in the cycle data updates
overrun  output  1  sticky: a stored bit was overwritten or shifted out

Behaviour:
- rst (async): all flops go to 0, including synchroniser chains and edge-detect history. data, captured, overrun and capture_pulse are 0; all_captured and match are therefore 0.
- Synchronisation: data_in and each strobe[i] pass through SYNC_STAGES flops. edge[i] = sync_strobe[i] & ~prev[i], where prev is one further flop.
- Sampled data bit: the data_in synchroniser output delayed one cycle, so it is aligned with edge.
- Latency: a strobe rising edge is first reflected in data/capture_pulse after SYNC_STAGES+1 rising clk edges.
- data_in requirement: stable for at least 2 clk cycles before and after the strobe rise.
- any_edge = |edge.
- Indexed mode (mode=0), for every i with edge[i]:
  - data[idx(i)] <= sampled bit; captured[idx(i)] <= 1.
  - If captured[idx(i)] was already 1, overrun <= 1 and the bit is still overwritten.
  - Simultaneous edges: all addressed bits are written with the same sampled bit in the same cycle.
- Shift mode (mode=1), on any_edge:
  - data <= {data[WIDTH-2:0], sampled bit}; captured <= {captured[WIDTH-2:0], 1}.
  - overrun <= 1 if captured[WIDTH-1] was 1 before the shift.
  - Multiple simultaneous edges count as exactly one shift.
- capture_pulse: registered; 1 for exactly one cycle, coincident with the data update; 0 otherwise.
- mode: sampled every cycle and applies to the edge present in that cycle. Changing mode never alters stored data or captured.
- clear: synchronous with highest priority. data, captured and overrun go to 0 next cycle, and any edge in the same cycle is discarded (no capture_pulse). Synchroniser and edge history are not cleared.
- all_captured and match: combinational from the registered data, captured and target. match drops as soon as target or data changes.
- Reset mid-operation: strobe edges still in the synchroniser are lost. A strobe held high through reset release produces one capture SYNC_STAGES+1 cycles after release, because the history resets to 0.
- Only static strobe-to-bit mapping is permitted. No logic is clocked by strobe or data_in directly.

Test Plan:
- Reset/idle: assert rst for 3 cycles, strobe=0 -> data=0x00, captured=0x00, overrun=0, match=0, no capture_pulse for 20 cycles.
- Indexed latency (WIDTH=8, SYNC_STAGES=2, REVERSE=1): data_in=1, raise strobe[0] -> exactly 3 clk edges later data=0x80, captured=0x80, capture_pulse high for 1 cycle.
- Fill and match: target=0xA5; strobe each channel once with the matching bits -> all_captured=1, match=1, overrun=0. Re-strobe strobe[7] (data[0]) with data_in=0 -> data=0xA4, overrun=1, match=0.
- Simultaneous edges: data_in=1, strobe[1] and strobe[2] rise in the same cycle -> data=0x60, captured=0x60, a single capture_pulse.
- Shift mode: mode=1, 9 strobe events with bits 1,0,1,1,0,0,1,0,1 -> after 8 events data=0xB2, all_captured=1, overrun=0; after the 9th, data=0x65, overrun=1.
- Clear/reset collision: clear asserted in the cycle an edge reaches the data register -> next cycle data=0x00, captured=0x00, no capture_pulse. rst pulsed while a strobe edge is in the synchroniser, strobe low before release -> no capture.

Source files
------------

// File: rtl/dff_capture_bank.sv
// Serial-bit capture bank: asynchronous per-channel strobes are synchronised and
// edge-detected, then write one stored bit each (indexed mode) or shift the bank.
module dff_capture_bank #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter bit REVERSE     = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             data_in,
  input  logic [WIDTH-1:0] strobe,
  input  logic             mode,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] captured,
  output logic             all_captured,
  output logic             match,
  output logic             capture_pulse,
  output logic             overrun
);

  localparam int LAST = SYNC_STAGES - 1;

  logic [SYNC_STAGES-1:0]            r_din_sync;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_strb_sync;
  logic [WIDTH-1:0]                  r_strb_prev;
  logic                              r_sample;
  logic [WIDTH-1:0]                  r_data;
  logic [WIDTH-1:0]                  r_captured;
  logic                              r_overrun;
  logic                              r_pulse;

  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_hit;
  logic             w_any_edge;
  logic [WIDTH-1:0] w_data_nxt;
  logic [WIDTH-1:0] w_capt_nxt;
  logic             w_ovr_nxt;
  logic             w_pulse_nxt;

  // Synchronisers and edge history.
  // NOTE: every flop, including the synchroniser chains, is reset so that a
  // strobe held high through reset release is seen as a fresh rising edge.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_din_sync  <= '0;
      r_strb_sync <= '0;
      r_strb_prev <= '0;
      r_sample    <= 1'b0;
    end else begin
      r_din_sync  <= {r_din_sync[SYNC_STAGES-2:0], data_in};
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], strobe};
      r_strb_prev <= r_strb_sync[LAST];
      r_sample    <= r_din_sync[LAST];
    end
  end

  assign w_edge     = r_strb_sync[LAST] & ~r_strb_prev;
  assign w_any_edge = |w_edge;

  // Static strobe-to-bit mapping.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (REVERSE) w_hit[WIDTH-1-i] = w_edge[i];
      else         w_hit[i]         = w_edge[i];
    end
  end

  // Next-state selection; clear outranks any edge present in the same cycle.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    w_data_nxt  = r_data;
    w_capt_nxt  = r_captured;
    w_ovr_nxt   = r_overrun;
    w_pulse_nxt = 1'b0;
    if (clear) begin
      w_data_nxt = '0;
      w_capt_nxt = '0;
      w_ovr_nxt  = 1'b0;
    end else if (w_any_edge) begin
      w_pulse_nxt = 1'b1;
      if (mode) begin
        w_data_nxt = {r_data[WIDTH-2:0], r_sample};
        w_capt_nxt = {r_captured[WIDTH-2:0], 1'b1};
        w_ovr_nxt  = r_overrun | r_captured[WIDTH-1];
      end else begin
        w_data_nxt = (r_data & ~w_hit) | (w_hit & {WIDTH{r_sample}});
        w_capt_nxt = r_captured | w_hit;
        w_ovr_nxt  = r_overrun | (|(w_hit & r_captured));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_captured <= '0;
      r_overrun  <= 1'b0;
      r_pulse    <= 1'b0;
    end else begin
      r_data     <= w_data_nxt;
      r_captured <= w_capt_nxt;
      r_overrun  <= w_ovr_nxt;
      r_pulse    <= w_pulse_nxt;
    end
  end

  assign data          = r_data;
  assign captured      = r_captured;
  assign overrun       = r_overrun;
  assign capture_pulse = r_pulse;
  assign all_captured  = &r_captured;
  assign match         = all_captured && (r_data == target);

endmodule

// File: tb/tb_dff_capture_bank.sv
// Scoreboard bench for dff_capture_bank (WIDTH=8, SYNC_STAGES=2, REVERSE=1).
module tb_dff_capture_bank;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         data_in = 1'b0;
  logic [W-1:0] strobe = '0;
  logic         mode = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] target = '0;
  logic [W-1:0] data;
  logic [W-1:0] captured;
  logic         all_captured;
  logic         match;
  logic         capture_pulse;
  logic         overrun;

  typedef struct packed {
    logic [W-1:0] data;
    logic [W-1:0] capt;
    logic         ovr;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] m_data = '0;
  logic [W-1:0] m_capt = '0;
  logic         m_ovr  = 1'b0;
  int           total = 0;
  int           bad   = 0;

  dff_capture_bank #(.WIDTH(W), .SYNC_STAGES(2), .REVERSE(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .strobe(strobe), .mode(mode),
    .clear(clear), .target(target), .data(data), .captured(captured),
    .all_captured(all_captured), .match(match), .capture_pulse(capture_pulse),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour: channel i addresses bit W-1-i.
  task automatic model_apply(input logic [W-1:0] mask, input logic val);
    if (mode) begin
      m_ovr  = m_ovr | m_capt[W-1];
      m_data = {m_data[W-2:0], val};
      m_capt = {m_capt[W-2:0], 1'b1};
    end else begin
      for (int i = 0; i < W; i++) begin
        if (mask[i]) begin
          if (m_capt[W-1-i]) m_ovr = 1'b1;
          m_data[W-1-i] = val;
          m_capt[W-1-i] = 1'b1;
        end
      end
    end
  endtask

  task automatic model_clear();
    m_data = '0;
    m_capt = '0;
    m_ovr  = 1'b0;
  endtask

  task automatic strobe_event(input logic [W-1:0] mask, input logic val);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    data_in = val;
    repeat (2) @(negedge clk);
    model_apply(mask, val);
    sb.push_back('{data: m_data, capt: m_capt, ovr: m_ovr});
    strobe = mask;
    n = 0;
    seen = 0;
    while (!seen && n < 10) begin
      @(posedge clk);
      #1;
      n++;
      if (capture_pulse) seen = 1;
    end
    if (!seen) begin
      check("pulse_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check("latency", n, 3);
      check("data", data, e.data);
      check("captured", captured, e.capt);
      check("overrun", overrun, e.ovr);
      @(posedge clk);
      #1;
      check("pulse_width", capture_pulse, 1'b0);
    end
    @(negedge clk);
    strobe = '0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
    check("clear_data", data, 0);
    check("clear_capt", captured, 0);
    check("clear_ovr", overrun, 0);
  endtask

  logic [W-1:0] pat;
  logic [8:0]   shift_bits;
  bit           any_pulse;

  initial begin
    // Reset and idle
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_data", data, 0);
    check("rst_capt", captured, 0);
    check("rst_ovr", overrun, 0);
    check("rst_all", all_captured, 0);
    check("rst_match", match, 0);
    any_pulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (capture_pulse) any_pulse = 1;
    end
    check("idle_pulse", any_pulse, 0);

    // Indexed latency: strobe[0] writes data[7]
    strobe_event(8'h01, 1'b1);
    check("lat_data80", data, 8'h80);
    do_clear();

    // Fill to 0xA5 and match
    pat = 8'hA5;
    target = pat;
    for (int i = 0; i < W; i++) strobe_event(W'(1) << i, pat[W-1-i]);
    check("fill_all", all_captured, 1);
    check("fill_match", match, 1);
    check("fill_ovr", overrun, 0);
    @(negedge clk);
    target = 8'h00;
    #1;
    check("match_target_drop", match, 0);
    @(negedge clk);
    target = pat;
    #1;
    check("match_target_back", match, 1);
    strobe_event(8'h80, 1'b0);
    check("rewrite_data", data, 8'hA4);
    check("rewrite_ovr", overrun, 1);
    check("rewrite_match", match, 0);
    do_clear();

    // Simultaneous edges: channels 1 and 2 -> bits 6 and 5
    strobe_event(8'h06, 1'b1);
    check("simul_data", data, 8'h60);
    do_clear();

    // Mode change alone leaves state untouched
    strobe_event(8'h10, 1'b1);
    @(negedge clk);
    mode = 1'b1;
    repeat (3) @(negedge clk);
    check("mode_keep_data", data, m_data);
    check("mode_keep_capt", captured, m_capt);
    do_clear();

    // Shift mode: 9 events
    shift_bits = 9'b101100101;
    for (int k = 0; k < 9; k++) begin
      strobe_event(W'(1) << (k % W), shift_bits[8-k]);
      if (k == 7) begin
        check("shift8_data", data, 8'hB2);
        check("shift8_all", all_captured, 1);
        check("shift8_ovr", overrun, 0);
      end
    end
    check("shift9_data", data, 8'h65);
    check("shift9_ovr", overrun, 1);
    @(negedge clk);
    mode = 1'b0;

    // Clear collides with an edge reaching the data register
    data_in = 1'b1;
    repeat (2) @(negedge clk);
    strobe = 8'h01;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    model_clear();
    check("coll_pulse", capture_pulse, 0);
    check("coll_data", data, 0);
    check("coll_capt", captured, 0);
    @(negedge clk);
    strobe = '0;
    repeat (4) @(negedge clk);

    // Reset while an edge is in the synchroniser
    strobe = 8'h02;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    strobe = '0;
    @(negedge clk);
    rst = 1'b0;
    any_pulse = 0;
    repeat (10) begin
      @(negedge clk);
      if (capture_pulse) any_pulse = 1;
    end
    check("rstmid_pulse", any_pulse, 0);
    check("rstmid_data", data, 0);
    check("rstmid_capt", captured, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
